joy_db15_tx: RTL and testbench
==============================

JOY_DB15_TX -- requirements
Module: joy_db15_tx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 32, meaning the number of data bits shifted per frame; the only legal value is 32.
REQ-002 SHALL have parameter TIMEOUT, default 24'd480000, meaning the number of idle clk cycles (10 ms at 48 MHz) without a load before `active` deasserts.
REQ-003 SHALL have port clk, input, 1, the single system clock (40-50 MHz); all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port joy1_in, input, 16, player-1 buttons, active-high, in LS FEDCBAUDLR order.
REQ-006 SHALL have port joy2_in, input, 16, player-2 buttons, same format as joy1_in.
REQ-007 SHALL have port JOY_LOAD, input, 1, asynchronous parallel-load strobe from the reader, active-low.
REQ-008 SHALL have port JOY_CLK, input, 1, asynchronous shift clock from the reader; it shifts on its rising edge.
REQ-009 SHALL have port JOY_DATA, output, 1, serial data to the reader, active-low (0 = pressed).
REQ-010 SHALL have port frame_done, output, 1, a one-cycle pulse when the 32nd shift completes.
REQ-011 SHALL have port overrun, output, 1, sticky, set when a shift arrives after the 32nd shift.
REQ-012 SHALL have port frame_cnt, output, 8, the count of completed frames; it wraps from 255 to 0.
REQ-013 SHALL have port active, output, 1, high while loads keep arriving within TIMEOUT cycles.

Function
REQ-014 SHALL pass JOY_LOAD and JOY_CLK each through a 3-flop chain s1->s2->s3; shift_evt = clk_s2 & ~clk_s3; load_lvl = ~load_s2.
REQ-015 SHALL hold a 32-bit shift register sr and a 6-bit bit counter bitcnt (range 0..32).
REQ-016 SHALL drive JOY_DATA = ~sr[31] straight from the register, with no extra pipeline stage.
REQ-017 SHALL, while load_lvl=1 on any cycle: load sr <= {joy1_in, joy2_in}, set bitcnt <= 0, clear overrun, and ignore shift_evt (load has priority over shift).
REQ-018 SHALL, when load_lvl=0, shift_evt=1 and bitcnt<32: shift sr left by one with 0 filled at bit 0 (released on the wire), and increment bitcnt.
REQ-019 SHALL, when shift_evt=1 takes bitcnt from 31 to 32: assert frame_done on the next cycle only, and increment frame_cnt modulo 256.
REQ-020 SHALL, when load_lvl=0, shift_evt=1 and bitcnt=32: leave sr and bitcnt unchanged and set overrun (JOY_DATA stays 1).
REQ-021 SHALL, at latency: when the JOY_CLK pin is first sampled high at edge n, apply the shift at edge n+2 so that JOY_DATA changes after edge n+2; JOY_LOAD→sr has the same latency.
REQ-022 SHALL keep the first bit on the wire as ~joy1_in[15] (valid after load) and the 32nd bit as ~joy2_in[0].
REQ-023 SHALL let joy1_in/joy2_in changes during shifting have no effect until the next load.
REQ-024 SHALL run a 24-bit idle counter: reset it to 0 on each cycle with load_lvl=1; otherwise increment it, saturating at TIMEOUT.
REQ-025 SHALL drive active=1 while the idle counter < TIMEOUT, and active=0 at or beyond TIMEOUT.
REQ-026 SHALL, when a load occurs in the same cycle as a frame completion, follow load priority: no frame_done and no frame_cnt increment.

Reset
REQ-027 SHALL, on RESET=1 at a clk edge: clear sr, set bitcnt=32 (no stale frame), set frame_done=0, overrun=0, frame_cnt=0, set the idle counter=TIMEOUT (active=0), set all sync flops to 1 (JOY_LOAD idle, JOY_CLK high), and so JOY_DATA=1.
REQ-028 SHALL treat RESET mid-frame the same way: the frame is abandoned without frame_done, and a new load is required before valid data.
REQ-029 SHALL NOT, on RESET release with JOY_CLK already high, generate a shift_evt.

Verification
REQ-030 SHALL be covered by scenario "nominal frame": joy1_in=16'h8001, joy2_in=16'h0003, LOAD low 4 cycles, then 32 CLK pulses at 8 clk period -> wire bits 0,1×14,0,1×14,0,0 in order; frame_done pulses once; frame_cnt=1.
REQ-031 SHALL be covered by scenario "overrun": after a full frame, 3 extra CLK pulses -> JOY_DATA=1, overrun=1, frame_cnt unchanged; next LOAD clears overrun.
REQ-032 SHALL be covered by scenario "load priority": CLK rising in the same cycle as LOAD low -> sr reloaded, bitcnt=0, no shift, first bit = ~joy1_in[15].
REQ-033 SHALL be covered by scenario "reset mid-frame": RESET after 10 shifts -> JOY_DATA=1, no frame_done, frame_cnt=0, active=0; subsequent CLK pulses without LOAD do nothing.
REQ-034 SHALL be covered by scenario "timeout/wrap": TIMEOUT=100 override, loads stopped -> active falls exactly 100 cycles after the last load cycle; 256 frames -> frame_cnt returns to 0.
REQ-035 SHALL be covered by scenario "latency": a JOY_CLK edge placed mid-cycle -> JOY_DATA transition observed exactly after the 3rd clk edge counting the sampling edge as the 1st.

Source files
------------

// File: rtl/joy_db15_tx.sv
`default_nettype none
// ============================================================================
//  Module   : joy_db15_tx
//  Purpose  : DB15 arcade-joystick serial transmitter; presents two 16-bit
//             button words to an external shift-register style reader.
//  Revision : 1.0 - initial release
// ============================================================================
module joy_db15_tx #(
    parameter int          FRAME_BITS = 32,
    parameter logic [23:0] TIMEOUT    = 24'd480000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [15:0] joy1_in,
    input  logic [15:0] joy2_in,
    input  logic        JOY_LOAD,
    input  logic        JOY_CLK,
    output logic        JOY_DATA,
    output logic        frame_done,
    output logic        overrun,
    output logic [7:0]  frame_cnt
    ,
    output logic        active
);

    localparam logic [5:0] c_full = 6'(FRAME_BITS);
    localparam logic [5:0] c_last = 6'(FRAME_BITS - 1);

    logic                  r_load_s1, r_load_s2, r_load_s3;
    logic                  r_clk_s1,  r_clk_s2,  r_clk_s3;
    logic [FRAME_BITS-1:0] r_sr;
    logic [5:0]            r_bitcnt;
    logic                  r_frame_done;
    logic                  r_overrun;
    logic [7:0]            r_frame_cnt;
    logic [23:0]           r_idle;

    logic w_shift_evt;
    logic w_load_lvl;
    logic w_unused_load_s3;

    assign w_shift_evt      = r_clk_s2 & ~r_clk_s3;
    assign w_load_lvl       = ~r_load_s2;
    // The third load flop only mirrors the clock chain's depth.
    assign w_unused_load_s3 = r_load_s3;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_load_s1 <= 1'b1;
            r_load_s2 <= 1'b1;
            r_load_s3 <= 1'b1;
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_s3  <= 1'b1;
        end else begin
            r_load_s1 <= JOY_LOAD;
            r_load_s2 <= r_load_s1;
            r_load_s3 <= r_load_s2;
            r_clk_s1  <= JOY_CLK;
            r_clk_s2  <= r_clk_s1;
            r_clk_s3  <= r_clk_s2;
        end
    end

    // Load wins over a coincident shift; bitcnt parks at c_full after a frame.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_sr         <= '0;
            r_bitcnt     <= c_full;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_load_lvl) begin
                r_sr      <= {joy1_in, joy2_in};
                r_bitcnt  <= 6'd0;
                r_overrun <= 1'b0;
            end else if (w_shift_evt) begin
                if (r_bitcnt != c_full) begin
                    r_sr     <= {r_sr[FRAME_BITS-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 6'd1;
                    if (r_bitcnt == c_last) begin
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 8'd1;
                    end
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_idle <= TIMEOUT;
        end else if (w_load_lvl) begin
            r_idle <= 24'd0;
        end else if (r_idle < TIMEOUT) begin
            r_idle <= r_idle + 24'd1;
        end
    end

    assign JOY_DATA   = ~r_sr[FRAME_BITS-1];
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;
    assign frame_cnt  = r_frame_cnt;
    assign active     = (r_idle < TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_joy_db15_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_joy_db15_tx
//  Purpose  : Self-checking bench for joy_db15_tx with a wire-bit scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_joy_db15_tx;

    logic        clk;
    logic        RESET;
    logic [15:0] joy1_in;
    logic [15:0] joy2_in;
    logic        JOY_LOAD;
    logic        JOY_CLK;
    logic        JOY_DATA,   JOY_DATA_t;
    logic        frame_done, frame_done_t;
    logic        overrun,    overrun_t;
    logic [7:0]  frame_cnt,  frame_cnt_t;
    logic        active,     active_t;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    int fd0;
    logic last_bit;
    logic exp_q[$];

    joy_db15_tx dut (
        .clk        (clk),
        .RESET      (RESET),
        .joy1_in    (joy1_in),
        .joy2_in    (joy2_in),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_CLK    (JOY_CLK),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt),
        .active     (active)
    );

    joy_db15_tx #(.TIMEOUT(24'd100)) dut_t (
        .clk        (clk),
        .RESET      (RESET),
        .joy1_in    (joy1_in),
        .joy2_in    (joy2_in),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_CLK    (JOY_CLK),
        .JOY_DATA   (JOY_DATA_t),
        .frame_done (frame_done_t),
        .overrun    (overrun_t),
        .frame_cnt  (frame_cnt_t),
        .active     (active_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected wire sequence: 32 inverted data bits MSB first, then released (1).
    task automatic push_frame(input logic [15:0] j1, input logic [15:0] j2);
        logic [31:0] v;
        v = {j1, j2};
        exp_q.delete();
        for (int i = 31; i >= 0; i--) exp_q.push_back(~v[i]);
        exp_q.push_back(1'b1);
        joy1_in = j1;
        joy2_in = j2;
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard empty got=%0b", tag, JOY_DATA);
        end else begin
            last_bit = exp_q.pop_front();
            chk(tag, 32'(JOY_DATA), 32'(last_bit));
        end
    endtask

    task automatic do_load();
        @(negedge clk) JOY_LOAD = 1'b0;
        repeat (4) @(negedge clk);
        JOY_LOAD = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        @(negedge clk) JOY_CLK = 1'b1;
        repeat (hi) @(negedge clk);
        JOY_CLK = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic run_pulses(input int n, input int hi, input int lo, input bit do_chk, input string tag);
        for (int i = 0; i < n; i++) begin
            pulse(hi, lo);
            if (do_chk) pop_chk(tag);
        end
    endtask

    initial begin
        RESET    = 1'b1;
        JOY_LOAD = 1'b1;
        JOY_CLK  = 1'b1;
        joy1_in  = 16'h0;
        joy2_in  = 16'h0;
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_data",   32'(JOY_DATA),   32'd1);
        chk("rst_fd",     32'(frame_done), 32'd0);
        chk("rst_ovr",    32'(overrun),    32'd0);
        chk("rst_fcnt",   32'(frame_cnt),  32'd0);
        chk("rst_active", 32'(active),     32'd0);
        chk("rst_act_t",  32'(active_t),   32'd0);
        JOY_CLK = 1'b0;
        repeat (4) @(negedge clk);

        // nominal frame
        fd0 = fd_cnt;
        push_frame(16'h8001, 16'h0003);
        do_load();
        pop_chk("nom_bit");
        run_pulses(32, 4, 4, 1'b1, "nom_bit");
        chk("nom_fd_cnt", 32'(fd_cnt - fd0), 32'd1);
        chk("nom_fcnt",   32'(frame_cnt),    32'd1);
        chk("nom_active", 32'(active),       32'd1);

        // overrun
        run_pulses(3, 4, 4, 1'b0, "ovr");
        chk("ovr_data", 32'(JOY_DATA),  32'd1);
        chk("ovr_flag", 32'(overrun),   32'd1);
        chk("ovr_fcnt", 32'(frame_cnt), 32'd1);
        push_frame(16'hA5A5, 16'h3C3C);
        do_load();
        chk("ovr_clear", 32'(overrun), 32'd0);
        pop_chk("lat_bit0");

        // latency: pin rises mid-cycle, data must move only after the 3rd edge
        @(negedge clk) JOY_CLK = 1'b1;
        @(posedge clk) #1 chk("lat_e1", 32'(JOY_DATA), 32'(last_bit));
        @(posedge clk) #1 chk("lat_e2", 32'(JOY_DATA), 32'(last_bit));
        @(posedge clk) #1 pop_chk("lat_e3");
        repeat (2) @(negedge clk);
        JOY_CLK = 1'b0;
        repeat (4) @(negedge clk);
        run_pulses(31, 4, 4, 1'b1, "lat_bit");
        chk("lat_fcnt", 32'(frame_cnt), 32'd2);

        // load priority: clock edge coincident with load, mid-frame
        push_frame(16'h1234, 16'h5678);
        do_load();
        pop_chk("pri_pre");
        run_pulses(5, 4, 4, 1'b1, "pri_pre");
        fd0 = fd_cnt;
        push_frame(16'hF00F, 16'h0FF0);
        @(negedge clk);
        JOY_LOAD = 1'b0;
        JOY_CLK  = 1'b1;
        repeat (4) @(negedge clk);
        JOY_LOAD = 1'b1;
        repeat (4) @(negedge clk);
        JOY_CLK = 1'b0;
        repeat (4) @(negedge clk);
        pop_chk("pri_bit");
        run_pulses(32, 4, 4, 1'b1, "pri_bit");
        chk("pri_fd_cnt", 32'(fd_cnt - fd0), 32'd1);
        chk("pri_fcnt",   32'(frame_cnt),    32'd3);

        // reset mid-frame
        push_frame(16'hFFFF, 16'hFFFF);
        do_load();
        pop_chk("rmf_bit");
        run_pulses(10, 4, 4, 1'b1, "rmf_bit");
        fd0 = fd_cnt;
        @(negedge clk) RESET = 1'b1;
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        repeat (2) @(negedge clk);
        chk("rmf_data",   32'(JOY_DATA),     32'd1);
        chk("rmf_fcnt",   32'(frame_cnt),    32'd0);
        chk("rmf_active", 32'(active),       32'd0);
        chk("rmf_fd",     32'(fd_cnt - fd0), 32'd0);
        run_pulses(5, 4, 4, 1'b0, "rmf_post");
        chk("rmf_post_data", 32'(JOY_DATA),     32'd1);
        chk("rmf_post_fcnt", 32'(frame_cnt),    32'd0);
        chk("rmf_post_fd",   32'(fd_cnt - fd0), 32'd0);

        // timeout: last load-level cycle ends 2 edges after pin release
        push_frame(16'h0F0F, 16'hF0F0);
        @(negedge clk) JOY_LOAD = 1'b0;
        repeat (4) @(negedge clk);
        JOY_LOAD = 1'b1;
        for (int k = 1; k <= 102; k++) begin
            @(posedge clk) #1;
            if (k == 101) chk("to_active_101", 32'(active_t), 32'd1);
            if (k == 102) chk("to_active_102", 32'(active_t), 32'd0);
        end

        // frame counter wrap
        fd0 = fd_cnt;
        for (int f = 0; f < 256; f++) begin
            push_frame(16'($urandom), 16'($urandom));
            do_load();
            if (f < 2) pop_chk("wrap_bit");
            run_pulses(32, 2, 2, (f < 2), "wrap_bit");
            if (f == 254) chk("wrap_fcnt_255", 32'(frame_cnt), 32'd255);
        end
        chk("wrap_fcnt_0", 32'(frame_cnt),    32'd0);
        chk("wrap_fd_cnt", 32'(fd_cnt - fd0), 32'd256);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
